// File: rtl/tone_bank.sv
// tone_bank: bank of gated square-wave voices with a saturating mixer.
// Every channel has a run-time half-period divider written over the cfg port.
// A channel sounds only while its key is high and its divider is non-zero.
// All channel tones are summed into one registered, clipped sample. A count
// of armed voices is registered alongside that sample.
module tone_bank #(
    parameter int NUM_CH = 36,
    parameter int DIV_W  = 20,
    parameter int AMP_W  = 12,
    parameter int OUT_W  = 16,
    localparam int ADDR_W  = ($clog2(NUM_CH) > 1) ? $clog2(NUM_CH) : 1,
    localparam int VOICE_W = $clog2(NUM_CH + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH-1:0]       key,
    input  logic [AMP_W-1:0]        level,
    input  logic                    cfg_we,
    input  logic [ADDR_W-1:0]       cfg_addr,
    input  logic [DIV_W-1:0]        cfg_div,
    output logic [NUM_CH*AMP_W-1:0] tone,
    output logic [OUT_W-1:0]        mix,
    output logic [VOICE_W-1:0]      voices
);

    // The sum gets one spare bit above the worst case, so it never wraps
    // before the clip. The compare width covers both the sum and the output
    // range, so the clip threshold is representable whichever is wider.
    localparam int SUM_W = AMP_W + $clog2(NUM_CH) + 1;
    localparam int CMP_W = (SUM_W > OUT_W) ? SUM_W : OUT_W;
    localparam logic [CMP_W-1:0] MIX_MAX = CMP_W'({OUT_W{1'b1}});

    logic [NUM_CH-1:0] armed;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [DIV_W-1:0] div_r;
        logic [DIV_W-1:0] cnt_r;
        logic             phase_r;
        logic [AMP_W-1:0] lvl_r;
        logic             wr_hit;

        // Addresses with no matching channel simply hit nothing.
        assign wr_hit   = cfg_we && (cfg_addr == ADDR_W'(g));
        assign armed[g] = key[g] && (div_r != '0);
        assign tone[g*AMP_W +: AMP_W] = phase_r ? lvl_r : '0;

        // Per-voice divider/phase state.
        // A config write wins over counting, but un-arming still forces the
        // phase low. Level is latched only on a rising half-cycle.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                div_r   <= '0;
                cnt_r   <= '0;
                phase_r <= 1'b0;
                lvl_r   <= '0;
            end else if (wr_hit) begin
                div_r <= cfg_div;
                cnt_r <= '0;
                if (!armed[g]) begin
                    phase_r <= 1'b0;
                end
            end else if (!armed[g]) begin
                cnt_r   <= '0;
                phase_r <= 1'b0;
            end else if (cnt_r == div_r) begin
                cnt_r   <= '0;
                phase_r <= ~phase_r;
                if (!phase_r) begin
                    lvl_r <= level;
                end
            end else begin
                cnt_r <= cnt_r + DIV_W'(1);
            end
        end
    end

    logic [SUM_W-1:0]   sum_c;
    logic [VOICE_W-1:0] voices_c;
    logic [CMP_W-1:0]   sum_ext;
    logic [OUT_W-1:0]   mix_c;

    // Sum the tone fields and count the armed channels.
    always_comb begin
        sum_c    = '0;
        voices_c = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            sum_c    = sum_c + SUM_W'(tone[i*AMP_W +: AMP_W]);
            voices_c = voices_c + VOICE_W'(armed[i]);
        end
    end

    assign sum_ext = CMP_W'(sum_c);
    assign mix_c   = (sum_ext > MIX_MAX) ? OUT_W'(MIX_MAX) : OUT_W'(sum_ext);

    // Register the clipped mix and the voice count, one cycle behind the tones.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mix    <= '0;
            voices <= '0;
        end else begin
            mix    <= mix_c;
            voices <= voices_c;
        end
    end

endmodule

// File: tb/tb_tone_bank.sv
// Directed bench for tone_bank (4 channels, 8-bit divider, 4-bit amplitude,
// 5-bit mix). Stimulus pushes hand-derived expectations tagged with the clock
// edge they apply after. A monitor compares them on the falling edge.
// A second 3-channel instance provides an out-of-range write address.
module tb_tone_bank;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  key;
    logic [3:0]  level;
    logic        cfg_we;
    logic [1:0]  cfg_addr;
    logic [7:0]  cfg_div;
    logic [15:0] tone;
    logic [4:0]  mix;
    logic [2:0]  voices;

    logic [2:0]  key2;
    logic        cfg_we2;
    logic [1:0]  cfg_addr2;
    logic [7:0]  cfg_div2;
    logic [11:0] tone2;
    logic [4:0]  mix2;
    logic [1:0]  voices2;

    tone_bank #(.NUM_CH(4), .DIV_W(8), .AMP_W(4), .OUT_W(5)) dut (
        .clk(clk), .rst(rst), .key(key), .level(level),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_div(cfg_div),
        .tone(tone), .mix(mix), .voices(voices)
    );

    tone_bank #(.NUM_CH(3), .DIV_W(8), .AMP_W(4), .OUT_W(5)) dut2 (
        .clk(clk), .rst(rst), .key(key2), .level(level),
        .cfg_we(cfg_we2), .cfg_addr(cfg_addr2), .cfg_div(cfg_div2),
        .tone(tone2), .mix(mix2), .voices(voices2)
    );

    always #5 clk = ~clk;

    int edge_n = 0;
    always @(posedge clk) edge_n <= edge_n + 1;

    // sel: 0 tone field ch, 1 mix, 2 voices, 3 full tone, 4 dut2 tone, 5 dut2 voices
    typedef struct {
        int    cyc;
        int    sel;
        int    ch;
        int    exp;
        string name;
    } chk_t;

    chk_t sb[$];
    int   n_checks = 0;
    int   n_err    = 0;

    task automatic expect_at(input int cyc, input int sel, input int ch,
                             input int exp, input string name);
        chk_t c;
        c.cyc  = cyc;
        c.sel  = sel;
        c.ch   = ch;
        c.exp  = exp;
        c.name = name;
        sb.push_back(c);
    endtask

    function automatic int actual(input int sel, input int ch);
        case (sel)
            0:       return int'(tone[ch*4 +: 4]);
            1:       return int'(mix);
            2:       return int'(voices);
            3:       return int'(tone);
            4:       return int'(tone2);
            default: return int'(voices2);
        endcase
    endfunction

    // Monitor: compare every expectation due at the current edge.
    always @(negedge clk) begin
        int i;
        int a;
        i = 0;
        while (i < sb.size()) begin
            if (sb[i].cyc < edge_n) begin
                n_checks++;
                n_err++;
                $display("FAIL %s: expectation for edge %0d not sampled (now %0d), expected %0d",
                         sb[i].name, sb[i].cyc, edge_n, sb[i].exp);
                sb.delete(i);
            end else if (sb[i].cyc == edge_n) begin
                a = actual(sb[i].sel, sb[i].ch);
                n_checks++;
                if (a != sb[i].exp) begin
                    n_err++;
                    $display("FAIL %s at edge %0d: got %0d, expected %0d",
                             sb[i].name, edge_n, a, sb[i].exp);
                end
                sb.delete(i);
            end else begin
                i++;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int k;
        int r0;
        int w;
        int t;
        int amp;

        rst = 1'b0; key = '0; level = '0; cfg_we = 1'b0; cfg_addr = '0; cfg_div = '0;
        key2 = '0; cfg_we2 = 1'b0; cfg_addr2 = '0; cfg_div2 = '0;

        // Reset values.
        expect_at(2, 3, 0, 0, "rst_tone");
        expect_at(2, 1, 0, 0, "rst_mix");
        expect_at(2, 2, 0, 0, "rst_voices");
        expect_at(2, 4, 0, 0, "rst_tone2");
        step(3);
        rst = 1'b1;

        // No dividers written: all keys down still silent.
        k = edge_n;
        key = 4'hF;
        level = 4'hA;
        for (int j = 1; j <= 100; j++) begin
            expect_at(k + j, 3, 0, 0, "idle_tone");
            expect_at(k + j, 1, 0, 0, "idle_mix");
            expect_at(k + j, 2, 0, 0, "idle_voices");
        end
        step(101);
        key = '0;
        step(2);

        // Channel 0, div 3: half-period 4 cycles, low half first.
        cfg_we = 1'b1; cfg_addr = 2'd0; cfg_div = 8'd3;
        step(1);
        cfg_we = 1'b0;
        k = edge_n;
        key[0] = 1'b1;
        for (int j = 1; j <= 20; j++) begin
            expect_at(k + j, 0, 0, ((j / 4) % 2 == 1) ? 10 : 0, "ch0_wave");
            expect_at(k + j, 2, 0, 1, "ch0_voices");
            if (j >= 2)
                expect_at(k + j, 1, 0, (((j - 1) / 4) % 2 == 1) ? 10 : 0, "ch0_mix");
        end
        step(20);

        // Level change while high: applies only from the next rise (edge k+28).
        level = 4'h3;
        for (int j = 21; j <= 29; j++) begin
            amp = (j < 24) ? 10 : 3;
            expect_at(k + j, 0, 0, ((j / 4) % 2 == 1) ? amp : 0, "lvl_change");
            expect_at(k + j, 2, 0, 1, "lvl_voices");
            amp = ((j - 1) < 24) ? 10 : 3;
            expect_at(k + j, 1, 0, (((j - 1) / 4) % 2 == 1) ? amp : 0, "lvl_mix");
        end
        step(9);

        // Key drop while high.
        r0 = edge_n;
        key[0] = 1'b0;
        expect_at(r0 + 1, 0, 0, 0, "drop_tone");
        expect_at(r0 + 1, 1, 0, 3, "drop_mix_lag");
        expect_at(r0 + 2, 1, 0, 0, "drop_mix");
        expect_at(r0 + 1, 2, 0, 0, "drop_voices");
        step(3);

        // Re-press: low half-cycle first.
        k = edge_n;
        key[0] = 1'b1;
        for (int j = 1; j <= 8; j++) begin
            expect_at(k + j, 0, 0, ((j / 4) % 2 == 1) ? 3 : 0, "repress");
            expect_at(k + j, 2, 0, 1, "repress_voices");
        end
        step(9);
        key[0] = 1'b0;
        step(3);

        // Channel 1: div 9, then rewrite to 5 mid-count (cnt=3).
        level = 4'h5;
        cfg_we = 1'b1; cfg_addr = 2'd1; cfg_div = 8'd9;
        step(1);
        cfg_we = 1'b0;
        key[1] = 1'b1;
        step(3);
        cfg_we = 1'b1; cfg_addr = 2'd1; cfg_div = 8'd5;
        w = edge_n + 1;
        for (int j = 1; j <= 12; j++) begin
            expect_at(w + j, 0, 1, (j >= 6 && j <= 11) ? 5 : 0, "rewrite_wave");
            expect_at(w + j, 2, 0, 1, "rewrite_voices");
        end
        expect_at(w + 6, 1, 0, 0, "rewrite_mix_lag");
        expect_at(w + 7, 1, 0, 5, "rewrite_mix");
        expect_at(w + 6, 0, 0, 0, "rewrite_ch0_quiet");
        step(1);
        cfg_we = 1'b0;
        step(13);
        key[1] = 1'b0;
        step(2);

        // 3-channel instance: address 3 is out of range and must be ignored.
        key2 = 3'b111;
        cfg_we2 = 1'b1; cfg_addr2 = 2'd3; cfg_div2 = 8'd1;
        t = edge_n;
        for (int j = 1; j <= 8; j++) begin
            expect_at(t + j, 4, 0, 0, "oob_tone");
            expect_at(t + j, 5, 0, 0, "oob_voices");
        end
        step(1);
        cfg_we2 = 1'b0;
        step(8);
        // Write with key already high: armed from the next cycle.
        cfg_we2 = 1'b1; cfg_addr2 = 2'd2; cfg_div2 = 8'd1;
        t = edge_n;
        expect_at(t + 1, 5, 0, 0, "wr2_voices_pre");
        expect_at(t + 2, 5, 0, 1, "wr2_voices");
        expect_at(t + 2, 4, 0, 0, "wr2_low");
        expect_at(t + 3, 4, 0, 1280, "wr2_rise");
        expect_at(t + 4, 4, 0, 1280, "wr2_high");
        expect_at(t + 5, 4, 0, 0, "wr2_fall");
        step(1);
        cfg_we2 = 1'b0;
        step(6);
        key2 = '0;
        step(2);

        // All four channels div 1, level F: overlap sums to 60, clipped at 31.
        level = 4'hF;
        for (int i = 0; i < 4; i++) begin
            cfg_we = 1'b1; cfg_addr = 2'(i); cfg_div = 8'd1;
            step(1);
        end
        cfg_we = 1'b0;
        k = edge_n;
        key = 4'hF;
        for (int j = 1; j <= 9; j++) begin
            expect_at(k + j, 3, 0, ((j / 2) % 2 == 1) ? 16'hFFFF : 0, "sat_tone");
            expect_at(k + j, 2, 0, 4, "sat_voices");
            if (j >= 2)
                expect_at(k + j, 1, 0, (((j - 1) / 2) % 2 == 1) ? 31 : 0, "sat_mix");
        end
        step(10);

        // Reset mid-note (tones just rose): outputs clear before the next edge.
        rst = 1'b0;
        expect_at(edge_n, 3, 0, 0, "arst_tone");
        expect_at(edge_n, 1, 0, 0, "arst_mix");
        expect_at(edge_n, 2, 0, 0, "arst_voices");
        step(2);
        rst = 1'b1;
        // Dividers cleared: keys still high but nothing sounds.
        k = edge_n;
        for (int j = 1; j <= 10; j++) begin
            expect_at(k + j, 3, 0, 0, "post_rst_tone");
            expect_at(k + j, 1, 0, 0, "post_rst_mix");
            expect_at(k + j, 2, 0, 0, "post_rst_voices");
        end
        step(12);
        key = '0;

        for (int i = 0; i < 50 && sb.size() > 0; i++) @(posedge clk);
        if (sb.size() > 0) begin
            n_checks += sb.size();
            n_err += sb.size();
            $display("FAIL drain: %0d expectations never sampled, expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
